// File: rtl/wrr_sp_arbiter_pkg.sv
// Shared types and constants for the write-path arbiter: the FSM state encoding,
// the mode select values and the select-width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam logic MODE_SP  = 1'b0;
  localparam logic MODE_WRR = 1'b1;

  function automatic int calcSelW(input int numPorts);
    return (numPorts < 2) ? 1 : $clog2(numPorts);
  endfunction

endpackage

// File: rtl/wrr_sp_arbiter_rr_pick.sv
// Round-robin picker: returns the first set bit of the eligible mask at or
// after the start pointer, wrapping from the top port back to port 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 16,
  parameter int SEL_W     = calcSelW(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_eligible,
  input  logic [SEL_W-1:0]     i_start,
  output logic [SEL_W-1:0]     o_winner,
  output logic                 o_found
);

  logic [2*NUM_PORTS-1:0] w_dbl;
  logic [SEL_W:0]         w_offset;
  logic [SEL_W:0]         w_sum;

  // The doubled mask shifted by the start pointer is the rotated request
  // vector, so a plain lowest-bit encoder gives the distance from the pointer.
  always_comb begin
    w_dbl    = {i_eligible, i_eligible} >> i_start;
    w_offset = '0;
    o_found  = 1'b0;
    for (int k = 2*NUM_PORTS-1; k >= 0; k--) begin
      if (w_dbl[k]) begin
        w_offset = (SEL_W+1)'(k);
        o_found  = 1'b1;
      end
    end
    w_sum = w_offset + {1'b0, i_start};
    if (w_sum >= (SEL_W+1)'(NUM_PORTS)) begin
      w_sum = w_sum - (SEL_W+1)'(NUM_PORTS);
    end
    o_winner = w_sum[SEL_W-1:0];
  end

endmodule

// File: rtl/wrr_sp_arbiter.sv
// Packet arbiter for the SRAM write path: strict-priority or weighted
// round-robin choice per packet, with the grant held until the winner's eop.
module wrr_sp_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 16,
  parameter int PRIO_W    = 3,
  parameter int SEL_W     = calcSelW(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sp0_wrr1,
  input  logic [NUM_PORTS-1:0]        ready,
  input  logic [NUM_PORTS-1:0]        eop,
  input  logic [NUM_PORTS*PRIO_W-1:0] priority_in,
  output logic [SEL_W-1:0]            select,
  output logic                        transfering,
  output logic                        busy
);

  localparam int CRED_W = PRIO_W + 1;

  state_t              r_state;
  logic [CRED_W-1:0]   r_credit [NUM_PORTS];
  logic [SEL_W-1:0]    r_rrPtr;

  logic [CRED_W-1:0]   w_weight  [NUM_PORTS];
  logic [CRED_W-1:0]   w_credEff [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_credNz;
  logic [NUM_PORTS-1:0] w_eligible;
  logic                w_reload;
  logic                w_anyReady;
  logic [SEL_W-1:0]    w_spWinner;
  logic [PRIO_W-1:0]   w_spBest;
  logic                w_spFound;
  logic [SEL_W-1:0]    w_wrrWinner;
  logic                w_wrrFound;
  logic [SEL_W-1:0]    w_winner;
  logic                w_doWrr;

  assign w_anyReady = |ready;

  // When no ready port has credit left, the bank is treated as reloaded in
  // this very cycle so the arbitration never stalls for a refill.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_weight[i] = {1'b0, priority_in[i*PRIO_W +: PRIO_W]} + CRED_W'(1);
      w_credNz[i] = (r_credit[i] != '0);
    end
    w_reload = ~|(ready & w_credNz);
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_credEff[i] = w_reload ? w_weight[i] : r_credit[i];
    end
    w_eligible = w_reload ? ready : (ready & w_credNz);
  end

  always_comb begin
    w_spWinner = '0;
    w_spBest   = '0;
    w_spFound  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ready[i] && (!w_spFound || (priority_in[i*PRIO_W +: PRIO_W] > w_spBest))) begin
        w_spWinner = SEL_W'(i);
        w_spBest   = priority_in[i*PRIO_W +: PRIO_W];
        w_spFound  = 1'b1;
      end
    end
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W)
  ) u_rrPick (
    .i_eligible (w_eligible),
    .i_start    (r_rrPtr),
    .o_winner   (w_wrrWinner),
    .o_found    (w_wrrFound)
  );

  assign w_winner = (sp0_wrr1 == MODE_WRR) ? w_wrrWinner : w_spWinner;
  assign w_doWrr  = (r_state == ST_ARB) && w_wrrFound && (sp0_wrr1 == MODE_WRR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      select      <= '0;
      transfering <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyReady) begin
            r_state <= ST_ARB;
            busy    <= 1'b1;
          end
        end
        ST_ARB: begin
          if (!w_anyReady) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            select      <= w_winner;
            transfering <= 1'b1;
            r_state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Only the granted port's eop ends the packet.
          if (eop[select]) begin
            transfering <= 1'b0;
            if (w_anyReady) begin
              r_state <= ST_ARB;
            end else begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          transfering <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Credits and the round-robin pointer only move on a WRR grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_credit[i] <= '0;
      end
      r_rrPtr <= '0;
    end else if (w_doWrr) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (SEL_W'(i) == w_wrrWinner) begin
          r_credit[i] <= w_credEff[i] - CRED_W'(1);
        end else if (w_reload) begin
          r_credit[i] <= w_weight[i];
        end
      end
      r_rrPtr <= (w_wrrWinner == SEL_W'(NUM_PORTS-1)) ? '0 : (w_wrrWinner + SEL_W'(1));
    end
  end

endmodule

// File: tb/tb_wrr_sp_arbiter.sv
// Scoreboard bench for wrr_sp_arbiter: a packet-level reference model predicts
// each grant, and a monitor compares it whenever a new grant appears.
module tb_wrr_sp_arbiter;
  import arb_pkg::*;

  localparam int NP = 16;
  localparam int PW = 3;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sp0_wrr1;
  logic [NP-1:0]    ready;
  logic [NP-1:0]    eop;
  logic [NP*PW-1:0] priority_in;
  logic [SW-1:0]    select;
  logic             transfering;
  logic             busy;

  int            testsRun;
  int            testsFailed;
  int            expQ[$];
  int            obsLog[$];
  bit            logEn;
  bit            prevTrans;
  int            mCredit[NP];
  int            mPtr;
  logic [NP-1:0] curMask;
  bit            ok;
  int            expv;
  int            port0Cnt;

  always #5 clk = ~clk;

  wrr_sp_arbiter #(
    .NUM_PORTS (NP),
    .PRIO_W    (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sp0_wrr1    (sp0_wrr1),
    .ready       (ready),
    .eop         (eop),
    .priority_in (priority_in),
    .select      (select),
    .transfering (transfering),
    .busy        (busy)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int prioOf(input int i);
    return int'(priority_in[i*PW +: PW]);
  endfunction

  function automatic void setPrio(input int i, input int v);
    priority_in[i*PW +: PW] = PW'(v);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NP; i++) mCredit[i] = 0;
    mPtr = 0;
  endfunction

  // Packet-level reference: SP is "highest priority, lowest index on tie";
  // WRR is "next port from the pointer that still has credit, refilling all
  // credits to priority+1 when no ready port has any left".
  function automatic int modelGrant(input logic [NP-1:0] mask, input logic mode);
    int best;
    int win;
    bit any;
    best = -1;
    win  = -1;
    if (mode == MODE_SP) begin
      for (int i = 0; i < NP; i++)
        if (mask[i] && (best < 0 || prioOf(i) > prioOf(best))) best = i;
      return best;
    end
    any = 0;
    for (int i = 0; i < NP; i++) if (mask[i] && mCredit[i] > 0) any = 1;
    if (!any) for (int i = 0; i < NP; i++) mCredit[i] = prioOf(i) + 1;
    for (int k = 0; k < NP; k++) begin
      int idx;
      idx = (mPtr + k) % NP;
      if (win < 0 && mask[idx] && mCredit[idx] > 0) win = idx;
    end
    mCredit[win] = mCredit[win] - 1;
    mPtr = (win + 1) % NP;
    return win;
  endfunction

  // Monitor: every rising edge of transfering is a new grant to score.
  initial begin
    prevTrans = 1'b0;
    forever begin
      @(negedge clk);
      if (transfering === 1'b1 && !prevTrans) begin
        if (expQ.size() == 0) checkOutput("grantUnexpected", int'(select), -1);
        else checkOutput("grantSelect", int'(select), expQ.pop_front());
        if (logEn) obsLog.push_back(int'(select));
      end
      prevTrans = (transfering === 1'b1);
    end
  end

  task automatic waitGrant(input int expLat, output bit found);
    int cnt;
    cnt   = 0;
    found = 1'b0;
    while (cnt < 20) begin
      @(negedge clk);
      if (transfering === 1'b1) begin
        found = 1'b1;
        break;
      end
      cnt++;
    end
    if (!found) checkOutput("grantTimeout", 0, 1);
    else checkOutput("grantLatency", cnt, expLat);
  endtask

  task automatic finishPacket(input int expPort, input int len, input logic nextMode, input int junk);
    logic [NP-1:0] own;
    own = NP'(1) << expPort;
    for (int w = 0; w < len; w++) begin
      if (w == 0) sp0_wrr1 = nextMode;
      if (w == len - 1) begin
        eop   = own;
        ready = curMask;
      end else begin
        case (junk)
          1:       eop = ~own;
          2:       eop = NP'($urandom) & ~own;
          default: eop = '0;
        endcase
        if (junk == 2) ready = NP'($urandom & $urandom);
      end
      @(negedge clk);
      if (w < len - 1) begin
        checkOutput("holdGrant", int'(transfering), 1);
        checkOutput("holdSelect", int'(select), expPort);
      end
    end
    eop = '0;
    checkOutput("eopRelease", int'(transfering), 0);
    checkOutput("busyHeld", int'(busy), 1);
  endtask

  task automatic applyStimulus(input logic [NP-1:0] mask, input int len, input int expLat,
                               input logic nextMode, input int junk);
    int  expPort;
    bit  found;
    ready   = mask;
    curMask = mask;
    expPort = modelGrant(mask, sp0_wrr1);
    expQ.push_back(expPort);
    waitGrant(expLat, found);
    if (found) finishPacket(expPort, len, nextMode, junk);
  endtask

  task automatic goIdle();
    ready = '0;
    @(negedge clk);
    checkOutput("arbDropBusy", int'(busy), 0);
    checkOutput("arbDropTrans", int'(transfering), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NP-1:0] m;
    testsRun    = 0;
    testsFailed = 0;
    logEn       = 1'b0;
    rst_n       = 1'b0;
    ready       = '1;
    eop         = '0;
    priority_in = '0;
    sp0_wrr1    = MODE_SP;
    modelReset();

    // Reset holds everything low even with every port requesting.
    repeat (3) @(negedge clk);
    checkOutput("resetSelect", int'(select), 0);
    checkOutput("resetTrans", int'(transfering), 0);
    checkOutput("resetBusy", int'(busy), 0);
    curMask = '1;
    expv    = modelGrant('1, MODE_SP);
    expQ.push_back(expv);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("releaseBusy", int'(busy), 1);
    checkOutput("releaseTrans", int'(transfering), 0);
    waitGrant(0, ok);
    if (ok) finishPacket(expv, 1, MODE_SP, 0);
    goIdle();

    // Strict priority with a tie and a foreign eop mid-packet.
    priority_in = '0;
    setPrio(2, 3);
    setPrio(5, 7);
    setPrio(9, 7);
    obsLog.delete();
    logEn = 1'b1;
    applyStimulus(NP'(16'h0224), 4, 1, MODE_SP, 1);
    applyStimulus(NP'(16'h0204), 2, 0, MODE_SP, 1);
    logEn = 1'b0;
    checkOutput("spLogSize", obsLog.size(), 2);
    if (obsLog.size() >= 2) begin
      checkOutput("spTieWinner", obsLog[0], 5);
      checkOutput("spNextWinner", obsLog[1], 9);
    end
    goIdle();

    // A lone port at priority 0 still gets served.
    priority_in = '0;
    obsLog.delete();
    logEn = 1'b1;
    applyStimulus(NP'(16'h0010), 1, 1, MODE_SP, 0);
    logEn = 1'b0;
    checkOutput("spZeroPrioSize", obsLog.size(), 1);
    if (obsLog.size() >= 1) checkOutput("spZeroPrio", obsLog[0], 4);
    goIdle();

    // WRR: port 0 weight 3, all others weight 1, single-word packets.
    priority_in = '0;
    setPrio(0, 2);
    sp0_wrr1 = MODE_WRR;
    obsLog.delete();
    logEn = 1'b1;
    for (int p = 0; p < 54; p++) applyStimulus('1, 1, (p == 0) ? 1 : 0, MODE_WRR, 0);
    logEn = 1'b0;
    checkOutput("wrrLogSize", obsLog.size(), 54);
    if (obsLog.size() == 54) begin
      for (int i = 0; i < 18; i++) checkOutput("wrrSequence", obsLog[i], (i < 16) ? i : 0);
      port0Cnt = 0;
      for (int i = 18; i < 54; i++) if (obsLog[i] == 0) port0Cnt++;
      checkOutput("wrrPort0Share", port0Cnt, 6);
    end

    // Switch WRR -> SP while a packet is in flight; the next ARB uses SP.
    applyStimulus('1, 3, 0, MODE_SP, 0);
    setPrio(7, 5);
    obsLog.delete();
    logEn = 1'b1;
    applyStimulus('1, 1, 0, MODE_SP, 0);
    logEn = 1'b0;
    checkOutput("modeSwitchSize", obsLog.size(), 1);
    if (obsLog.size() >= 1) checkOutput("modeSwitchSp", obsLog[0], 7);

    // Random traffic: masks, priorities, modes, lengths and noise on eop/ready.
    for (int p = 0; p < 60; p++) begin
      do m = NP'($urandom & $urandom); while (m == '0);
      for (int i = 0; i < NP; i++) setPrio(i, int'($urandom_range(0, 7)));
      applyStimulus(m, int'($urandom_range(1, 4)), 0, logic'($urandom_range(0, 1)), 2);
    end
    goIdle();

    // Reset during XFER drops the grant on the next edge.
    priority_in = '0;
    sp0_wrr1    = MODE_SP;
    curMask     = NP'(16'h0008);
    ready       = curMask;
    expQ.push_back(modelGrant(curMask, MODE_SP));
    waitGrant(1, ok);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("xferResetSelect", int'(select), 0);
    checkOutput("xferResetTrans", int'(transfering), 0);
    checkOutput("xferResetBusy", int'(busy), 0);
    modelReset();
    rst_n = 1'b1;
    ready = '0;
    repeat (2) @(negedge clk);
    checkOutput("idleAfterReset", int'(busy), 0);
    checkOutput("queueDrain", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/wrr_sp_arbiter.md
# wrr_sp_arbiter

Parametrised successor to the write-path arbiter core. Selects one of `NUM_PORTS` ready input ports per packet, in either strict-priority (SP) or weighted-round-robin (WRR) mode, and holds the grant until that port's end-of-packet. It sits between the per-port input buffers and the SRAM write datapath, which uses `select` as its mux control.

## Interface
Parameters:
- `NUM_PORTS`, default 16: number of requesting ports, 2 or more.
- `PRIO_W`, default 3: width of each port's priority/weight field.
- `SEL_W`, default `$clog2(NUM_PORTS)`: width of `select`; derived, never overridden.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `sp0_wrr1`  in  1: mode; 0 = SP, 1 = WRR. Sampled only in ARB.
- `ready`  in  NUM_PORTS: port i has a packet waiting.
- `eop`  in  NUM_PORTS: port i is presenting its last word this cycle.
- `priority_in`  in  NUM_PORTS*PRIO_W: field i is bits `[(i+1)*PRIO_W-1 : i*PRIO_W]`. It is the SP priority and the WRR weight base.
- `select`  out  SEL_W: index of the granted port.
- `transfering`  out  1: grant active; `select` is valid.
- `busy`  out  1: arbiter is in ARB or XFER.

## Operation
States are IDLE, ARB and XFER.
- **IDLE:** if `|ready`, go to ARB and set `busy=1`. Otherwise stay.
- **ARB:**
  - If `ready==0`, return to IDLE with `busy=0` and no grant.
  - Otherwise compute the winner, register `select<=winner` and `transfering<=1`, then go to XFER.
- **XFER:**
  - Only `eop[select]` ends the grant. `eop` on any other port is ignored.
  - On `eop[select]`, `transfering<=0`.
  - If `ready` (sampled that same cycle) is non-zero, go to ARB with `busy` held at 1. Otherwise go to IDLE with `busy=0`.

SP winner:
- The ready port with the largest priority wins; priority 0 is a valid priority.
- On a tie, the lowest index wins.

WRR weights and credits:
- Weight of port i = `priority_in[i] + 1`, range 1..2^PRIO_W.
- Each port has a credit counter of PRIO_W+1 bits.
- The eligible set is the ports with `ready[i] && credit[i] != 0`.
- If the eligible set is empty while `ready != 0`, reload every credit to its weight in that same cycle. All ready ports then become eligible.

WRR winner and updates:
- The winner is the first eligible port at or after `rr_ptr`, searching upward and wrapping from NUM_PORTS-1 to 0.
- On grant: `credit[winner]` is decremented by 1. After a reload in the same cycle, it is written as weight-1.
- On grant: `rr_ptr <= (winner+1) mod NUM_PORTS`.

SP/WRR interaction:
- In SP mode, credits and `rr_ptr` are frozen.
- A mode change during XFER takes effect at the next ARB.

Other rules:
- A `ready` drop on the granted port during XFER does not end the grant.
- `priority_in` changes take effect at the next ARB or reload.

## Timing
- Reset values: `select=0`, `transfering=0`, `busy=0`, state IDLE, `rr_ptr=0`, all credits 0. The first WRR arbitration therefore forces a reload.
- Reset takes priority over every other event. A reset during XFER drops `transfering` on the next edge and discards the packet grant.
- Request to grant latency:
  - `ready` rising in IDLE at edge n gives `busy=1` at n+1.
  - `transfering=1` and a valid `select` follow at n+2.
- Back-to-back packets: `eop[select]` at edge m gives `transfering=0` at m+1 and the next grant at m+2. There is exactly one dead cycle between packets.
- `eop[select]` asserted on the first XFER cycle is legal (single-word packet).
- Concurrent `eop[select]` and a new `ready` on the same edge: the new request is seen, and the FSM goes to ARB.

## Structure
- Package `arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_ARB`, `ST_XFER`);
  - the mode constants `MODE_SP=0` and `MODE_WRR=1`;
  - the helper function computing `SEL_W`.
- Sub-module `rr_pick`:
  - parametrised on `NUM_PORTS`;
  - inputs are an eligible mask and a start pointer;
  - outputs are the winner index and a found flag;
  - implemented as a rotated, masked priority encoder;
  - instantiated once for the WRR path.
- The SP comparator tree and the credit bank stay in the top level.

## Test plan
- **Reset:** hold `rst_n=0` with `ready=16'hFFFF` -> all outputs 0. After release, `busy` rises 1 cycle later and `transfering` 2 cycles later.
- **SP:** `sp0_wrr1=0`, ready ports 2/5/9 with priorities 3/7/7 -> `select=5`. Drive `eop[9]` mid-packet -> grant unchanged. Drive `eop[5]` -> next grant `select=9` after one dead cycle.
- **SP, zero priority:** only port 4 ready, priority 0 -> `select=4` (no lockout).
- **WRR:** all 16 ready, priorities all 0 except port 0 = 2 (weight 3), each packet 1 word. Check the following grant sequences:
  - first 16 grants: 0,1,…,15;
  - next round: 0,0 ahead of the second credit reload;
  - long-run share: port 0 gets 3 of every 18 grants.
- **Mid-operation changes:**
  - mode switch from WRR to SP during XFER -> current grant completes, and the next ARB uses SP;
  - `ready` falls to 0 during ARB -> return to IDLE and `busy=0` with no grant;
  - reset asserted in XFER -> all outputs 0 at the next edge.
